// File: rtl/toom8_recompose.sv
// ============================================================================
// toom8_recompose: overlap-adds 15 Toom-8 product coefficients into a
// 2048-bit result and streams it out as 16 limbs of 128 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module toom8_recompose #(
  parameter int LIMB_W = 128,
  parameter int NCOEF  = 15,
  parameter int COEF_W = 260
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COEF_W-1:0]           in_coef,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LIMB_W-1:0]           out_limb,
  output logic [3:0]                  out_idx,
  output logic                        out_last,
  output logic [(NCOEF+1)*LIMB_W-1:0] product,
  output logic                        done,
  output logic                        err_ovf
);

  localparam int RW = COEF_W - LIMB_W + 1;
  localparam int SW = COEF_W + 1;
  localparam int PW = (NCOEF + 1) * LIMB_W;
  localparam logic [3:0] IDX_LAST  = 4'(NCOEF - 1);
  localparam logic [3:0] IDX_FLUSH = 4'(NCOEF);

  typedef enum logic [0:0] {ST_ACC, ST_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [RW-1:0]       r_q, r_d;
  logic                out_valid_q, out_valid_d;
  logic [LIMB_W-1:0]   out_limb_q, out_limb_d;
  logic [3:0]          out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic [PW-1:0]       product_q, product_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                slot_free;
  logic                accept;
  logic                flush_load;
  logic [SW-1:0]       sum;

  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    in_ready   = (state_q == ST_ACC) && slot_free;
    accept     = in_valid && in_ready;
    flush_load = (state_q == ST_FLUSH) && slot_free;
    sum        = {{(SW-RW){1'b0}}, r_q} + {1'b0, in_coef};

    state_d     = state_q;
    idx_d       = idx_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_limb_d  = out_limb_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    product_d   = product_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (accept) begin
      out_limb_d  = sum[LIMB_W-1:0];
      out_idx_d   = idx_q;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      product_d[int'(idx_q)*LIMB_W +: LIMB_W] = sum[LIMB_W-1:0];
      r_d         = sum[SW-1:LIMB_W];
      idx_d       = idx_q + 4'd1;
      if (idx_q == 4'd0) err_d = 1'b0;
      if (idx_q == IDX_LAST) state_d = ST_FLUSH;
    end else if (flush_load) begin
      // Whatever residue spills past the top limb means the result overflowed.
      out_limb_d  = r_q[LIMB_W-1:0];
      out_idx_d   = IDX_FLUSH;
      out_last_d  = 1'b1;
      out_valid_d = 1'b1;
      product_d[PW-1 -: LIMB_W] = r_q[LIMB_W-1:0];
      err_d       = |r_q[RW-1:LIMB_W];
      done_d      = 1'b1;
      r_d         = '0;
      idx_d       = 4'd0;
      state_d     = ST_ACC;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      idx_q       <= 4'd0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_limb_q  <= '0;
      out_idx_q   <= 4'd0;
      out_last_q  <= 1'b0;
      product_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_limb_q  <= out_limb_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      product_q   <= product_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_limb  = out_limb_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign product   = product_q;
  assign done      = done_q;
  assign err_ovf   = err_q;

endmodule

`default_nettype wire
